// File: rtl/matrix_mult_2x2_seq_pkg.sv
// Shared types and helpers for the 2x2 matrix multiplier and its downstream
// divider.
package matrix_pkg;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } mm_state_t;

    // Row-major element index inside a 2x2 block.
    function automatic int elem_idx(input int i, input int j);
        return 2 * i + j;
    endfunction

endpackage

// File: rtl/matrix_mult_2x2_seq_if.sv
// Start/busy/done handshake and operand/result buses for the 2x2 multiplier.
interface matrix_mult_2x2_seq_if #(
    parameter int DATA_W = 32
);
    logic                  start;
    logic [4*DATA_W-1:0]   a;
    logic [4*DATA_W-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DATA_W-1:0]   p;
    logic                  ovf;

    modport master (
        output start, a, b,
        input  busy, done, p, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, p, ovf
    );
endinterface

// File: rtl/matrix_mult_2x2_seq_mac_unit.sv
// Signed multiply-accumulate slice: combinational product and sum, registered
// accumulator, and a flag for sums that do not fit back into W bits.
module mac_unit #(
    parameter  int W  = 32,
    localparam int AW = 2 * W + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr,
    input  logic                init,
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    output logic [AW-1:0]       sum,
    output logic                sum_ovf
);
    logic [AW-1:0]         acc_q;
    logic signed [2*W-1:0] prod;
    logic [AW-W:0]         top_bits;

    always_comb begin
        prod     = x * y;
        sum      = (clr ? '0 : acc_q) + {prod[2*W-1], prod};
        // In range exactly when every bit from W-1 upward is a sign copy.
        top_bits = sum[AW-1:W-1];
        sum_ovf  = !((&top_bits) || !(|top_bits));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (init) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum;
        end
    end
endmodule

// File: rtl/matrix_mult_2x2_seq.sv
// Sequential signed 2x2 matrix multiplier P = A x B over one shared MAC,
// eight MAC cycles per product plus one DONE cycle.
//
//   state | meaning
//   IDLE  | waiting for start; p/ovf hold the last result
//   MAC   | step counter 0..7 drives one multiply-accumulate per cycle
//   DONE  | one cycle: p/ovf just updated; start here chains the next product
module matrix_mult_2x2_seq
    import matrix_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    matrix_mult_2x2_seq_if.slave  bus
);
    mm_state_t            state_q, state_d;
    logic                 accept;
    logic [2:0]           s_q;
    logic [4*DATA_W-1:0]  a_q, b_q;
    logic [DATA_W-1:0]    r_q [3];
    logic [2:0]           r_ovf_q;
    logic [4*DATA_W-1:0]  p_q;
    logic                 ovf_q;

    logic                 k_bit;
    logic [1:0]           e_idx;
    logic [DATA_W-1:0]    x_op, y_op;
    logic [ACC_W-1:0]     sum;
    logic                 sum_ovf;
    logic                 mac_en;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (s_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = MAC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign k_bit  = s_q[0];
    assign e_idx  = s_q[2:1];
    assign mac_en = (state_q == MAC);
    assign x_op   = a_q[elem_idx(int'(e_idx[1]), int'(k_bit)) * DATA_W +: DATA_W];
    assign y_op   = b_q[elem_idx(int'(k_bit), int'(e_idx[0])) * DATA_W +: DATA_W];

    mac_unit #(.W(DATA_W)) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (mac_en),
        .clr     (!k_bit),
        .init    (accept),
        .x       (x_op),
        .y       (y_op),
        .sum     (sum),
        .sum_ovf (sum_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q[0]  <= '0;
            r_q[1]  <= '0;
            r_q[2]  <= '0;
            r_ovf_q <= '0;
            p_q     <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            s_q <= '0;
            a_q <= bus.a;
            b_q <= bus.b;
        end else if (mac_en) begin
            s_q <= s_q + 3'd1;
            if (k_bit) begin
                case (e_idx)
                    2'd0: begin r_q[0] <= sum[DATA_W-1:0]; r_ovf_q[0] <= sum_ovf; end
                    2'd1: begin r_q[1] <= sum[DATA_W-1:0]; r_ovf_q[1] <= sum_ovf; end
                    2'd2: begin r_q[2] <= sum[DATA_W-1:0]; r_ovf_q[2] <= sum_ovf; end
                    default: begin
                        // Last element bypasses r so p is ready on entry to DONE.
                        p_q   <= {sum[DATA_W-1:0], r_q[2], r_q[1], r_q[0]};
                        ovf_q <= (|r_ovf_q) | sum_ovf;
                    end
                endcase
            end
        end
    end

    assign bus.busy = (state_q == MAC);
    assign bus.done = (state_q == DONE);
    assign bus.p    = p_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_matrix_mult_2x2_seq.sv
// Directed-vector bench for matrix_mult_2x2_seq: table of products plus
// handshake, abort and hold sequences.
module tb_matrix_mult_2x2_seq;
    localparam int W = 32;

    typedef struct {
        string          name;
        logic [4*W-1:0] a;
        logic [4*W-1:0] b;
        logic [4*W-1:0] p;
        logic           ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    matrix_mult_2x2_seq_if #(.DATA_W(W)) bus ();

    matrix_mult_2x2_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4*W-1:0] m(input int e00, input int e01,
                                         input int e10, input int e11);
        return {e11, e10, e01, e00};
    endfunction

    task automatic check_word(input string name, input logic [4*W-1:0] act,
                              input logic [4*W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Counts edges from acceptance to done; samples 1 time unit after each edge.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_product(input logic [4*W-1:0] av, input logic [4*W-1:0] bv,
                              output int lat, output int busy_cnt);
        @(negedge clk);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = '1;
        bus.b     = '1;
        wait_done(lat, busy_cnt);
    endtask

    vec_t vecs[7];
    int   lat, bc;
    logic seen_done;
    logic [4*W-1:0] p_basic, p_signed, ident;

    initial begin
        n_total = 0;
        n_pass  = 0;
        ident    = m(1, 0, 0, 1);
        p_basic  = m(19, 22, 43, 50);
        p_signed = m(-19, 22, 43, -50);

        vecs[0] = '{"basic",    m(1, 2, 3, 4),   m(5, 6, 7, 8),   p_basic, 1'b0};
        vecs[1] = '{"signed",   m(-1, 2, 3, -4), m(5, -6, -7, 8), p_signed, 1'b0};
        vecs[2] = '{"identity", ident, m(9, -3, 100000, -7), m(9, -3, 100000, -7), 1'b0};
        vecs[3] = '{"ovf_pos",  m(32'h7FFFFFFF, 0, 0, 1), m(2, 0, 0, 1),
                    m(32'hFFFFFFFE, 0, 0, 1), 1'b1};
        vecs[4] = '{"ovf_clear", ident, ident, ident, 1'b0};
        vecs[5] = '{"ovf_minsq", m(32'h80000000, 0, 0, 0), m(32'h80000000, 0, 0, 0),
                    m(0, 0, 0, 0), 1'b1};
        vecs[6] = '{"edge_range", m(32'h40000000, 32'h3FFFFFFF, 32'hC0000000, 32'hC0000000),
                    m(1, 0, 1, 0), m(32'h7FFFFFFF, 0, 32'h80000000, 0), 1'b0};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #1;
        check_bit("rst_busy", bus.busy, 1'b0);
        check_bit("rst_done", bus.done, 1'b0);
        check_word("rst_p", bus.p, '0);
        check_bit("rst_ovf", bus.ovf, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            do_product(vecs[v].a, vecs[v].b, lat, bc);
            check_int({vecs[v].name, "_latency"}, lat, 8);
            check_int({vecs[v].name, "_busy_cycles"}, bc, 8);
            check_word({vecs[v].name, "_p"}, bus.p, vecs[v].p);
            check_bit({vecs[v].name, "_ovf"}, bus.ovf, vecs[v].ovf);
        end

        // Start held high, operands changed mid-product, back-to-back chain.
        @(negedge clk);
        bus.a     = vecs[0].a;
        bus.b     = vecs[0].b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.a = vecs[1].a;
        bus.b = vecs[1].b;
        wait_done(lat, bc);
        check_int("b2b_first_latency", lat, 8);
        check_word("b2b_first_p", bus.p, p_basic);
        wait_done(lat, bc);
        @(posedge clk);
        #1;
        wait_done(lat, bc);
        check_int("b2b_second_spacing", lat + 1, 9);
        check_int("b2b_second_busy", bc, 8);
        check_word("b2b_second_p", bus.p, p_signed);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check_bit("b2b_idle_busy", bus.busy, 1'b0);
        check_bit("b2b_idle_done", bus.done, 1'b0);

        // Result hold with start low.
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check_word("hold_p", bus.p, p_signed);
            check_int("hold_ovf_busy_done", int'({bus.ovf, bus.busy, bus.done}), 0);
        end

        // Reset mid-product at step 4.
        @(negedge clk);
        bus.a     = vecs[3].a;
        bus.b     = vecs[3].b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("abort_busy", bus.busy, 1'b0);
        check_bit("abort_done", bus.done, 1'b0);
        check_word("abort_p", bus.p, '0);
        check_bit("abort_ovf", bus.ovf, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        check_bit("abort_no_done", seen_done, 1'b0);
        check_word("abort_p_stays_zero", bus.p, '0);

        do_product(vecs[0].a, vecs[0].b, lat, bc);
        check_int("post_abort_latency", lat, 8);
        check_word("post_abort_p", bus.p, p_basic);
        check_bit("post_abort_ovf", bus.ovf, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
